// File: rtl/expand_mask_sampler.sv
// ExpandMask y-vector unpacker: turns a SHAKE256 squeeze stream into coefficients gamma1 - r mod q,
// with per-polynomial framing, output backpressure and a start/abort control path.
module expand_mask_sampler #(
  parameter int W        = 64,
  parameter int SAMPLE_W = 23,
  parameter int BUS_W    = 4,
  parameter int LANES    = 3,
  parameter int N        = 256
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [2:0]                  sec_lvl,
  input  logic                        start_i,
  input  logic                        abort_i,
  input  logic                        valid_i,
  output logic                        ready_i,
  input  logic [W-1:0]                rdi,
  output logic [SAMPLE_W*BUS_W-1:0]   samples,
  output logic                        valid_o,
  input  logic                        ready_o,
  output logic                        last_o,
  output logic                        busy_o,
  output logic                        done_o
);

  localparam int Q       = 8380417;
  localparam int MAX_RW  = 20;
  localparam int IN_CAP  = W + LANES * MAX_RW - 1;
  localparam int FILL_W  = $clog2(IN_CAP + 1);
  localparam int OUT_CAP = BUS_W + LANES;
  localparam int OCNT_W  = $clog2(OUT_CAP + 1);
  localparam int WORDS18 = (N * 18 + W - 1) / W;
  localparam int WORDS20 = (N * 20 + W - 1) / W;
  localparam int LAST18  = N * 18 - (WORDS18 - 1) * W;
  localparam int LAST20  = N * 20 - (WORDS20 - 1) * W;
  localparam int WCNT_W  = $clog2(WORDS20 + 1);
  localparam int CCNT_W  = $clog2(N + 1);
  localparam int BEATS   = N / BUS_W;
  localparam int BCNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                state_q, state_d;
  logic                  rw20_q, rw20_d;
  logic [IN_CAP-1:0]     in_buf_q, in_buf_d;
  logic [FILL_W-1:0]     in_fill_q, in_fill_d;
  logic [SAMPLE_W-1:0]   out_buf_q [OUT_CAP];
  logic [SAMPLE_W-1:0]   out_buf_d [OUT_CAP];
  logic [OCNT_W-1:0]     out_cnt_q, out_cnt_d;
  logic [WCNT_W-1:0]     words_in_q, words_in_d;
  logic [CCNT_W-1:0]     coeffs_q, coeffs_d;
  logic [BCNT_W-1:0]     beats_q, beats_d;
  logic                  done_q, done_d;

  int                    rw, words_lim, last_bits;
  int                    avail, kk, after_pop, rem, fill_new;
  logic [IN_CAP-1:0]     shifted;
  logic [19:0]           field;
  logic [SAMPLE_W-1:0]   coef [LANES];
  logic                  accept, pop, fin, go, clear;

  // Field r maps to gamma1 - r, folded into [0, Q-1] when r exceeds gamma1.
  function automatic logic [SAMPLE_W-1:0] map_coef(input logic [19:0] r, input logic wide);
    logic [23:0] g1, rr, res;
    g1 = wide ? 24'd524288 : 24'd131072;
    rr = {4'b0000, r};
    if (rr <= g1) res = g1 - rr;
    else          res = g1 + 24'(Q) - rr;
    return SAMPLE_W'(res);
  endfunction

  always_comb begin
    rw        = rw20_q ? 20 : 18;
    words_lim = rw20_q ? WORDS20 : WORDS18;
    last_bits = rw20_q ? LAST20 : LAST18;
  end

  assign busy_o  = (state_q != IDLE);
  assign valid_o = (out_cnt_q >= OCNT_W'(BUS_W));
  assign last_o  = valid_o && (beats_q == BCNT_W'(BEATS - 1));
  assign ready_i = (state_q == RUN) && (int'(in_fill_q) < LANES * rw)
                   && (int'(words_in_q) < words_lim);
  assign done_o  = done_q;

  always_comb begin
    samples = '0;
    for (int b = 0; b < BUS_W; b++) samples[b*SAMPLE_W +: SAMPLE_W] = out_buf_q[b];
  end

  always_comb begin
    field = '0;
    for (int j = 0; j < LANES; j++) begin
      if (rw20_q) field = in_buf_q[j*MAX_RW +: MAX_RW];
      else        field = {2'b00, in_buf_q[j*18 +: 18]};
      coef[j] = map_coef(field, rw20_q);
    end
  end

  always_comb begin
    accept    = valid_i && ready_i;
    pop       = valid_o && ready_o;
    fin       = pop && last_o;
    go        = (state_q == IDLE) && start_i;
    clear     = abort_i || go || fin;
    after_pop = pop ? int'(out_cnt_q) - BUS_W : int'(out_cnt_q);

    // Lanes this cycle: whole fields buffered, output room left after the pop, coefficients still owed.
    avail = 0;
    for (int j = 1; j <= LANES; j++) if (int'(in_fill_q) >= j * rw) avail = j;
    kk = avail;
    if (OUT_CAP - after_pop < kk) kk = OUT_CAP - after_pop;
    if (N - int'(coeffs_q) < kk)  kk = N - int'(coeffs_q);

    shifted  = in_buf_q >> (kk * rw);
    rem      = int'(in_fill_q) - kk * rw;
    fill_new = rem;
    if (accept) begin
      shifted  = shifted | (IN_CAP'(rdi) << rem);
      fill_new = rem + ((int'(words_in_q) == words_lim - 1) ? last_bits : W);
    end
    // Bits above the fill level are kept at zero so the next word can be OR-ed in.
    in_buf_d  = shifted & ~({IN_CAP{1'b1}} << fill_new);
    in_fill_d = FILL_W'(fill_new);

    for (int i = 0; i < OUT_CAP; i++) out_buf_d[i] = pop ? '0 : out_buf_q[i];
    if (pop) for (int s = BUS_W; s < OUT_CAP; s++) out_buf_d[s-BUS_W] = out_buf_q[s];
    for (int i = 0; i < OUT_CAP; i++) begin
      for (int j = 0; j < LANES; j++)
        if (j < kk && i == after_pop + j) out_buf_d[i] = coef[j];
      if (i >= after_pop + kk) out_buf_d[i] = '0;
    end
    out_cnt_d = OCNT_W'(after_pop + kk);

    words_in_d = accept ? words_in_q + 1'b1 : words_in_q;
    coeffs_d   = coeffs_q + CCNT_W'(kk);
    beats_d    = beats_q;
    if (pop) beats_d = (beats_q == BCNT_W'(BEATS - 1)) ? '0 : beats_q + 1'b1;

    state_d = state_q;
    rw20_d  = rw20_q;
    done_d  = fin;
    case (state_q)
      IDLE: if (start_i) begin
        state_d = RUN;
        rw20_d  = (sec_lvl != 3'd2);
      end
      RUN: begin
        if (fin) state_d = IDLE;
        else if (int'(words_in_d) == words_lim) state_d = DRAIN;
      end
      DRAIN: if (fin) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (clear) begin
      in_buf_d   = '0;
      in_fill_d  = '0;
      out_cnt_d  = '0;
      words_in_d = '0;
      coeffs_d   = '0;
      beats_d    = '0;
      for (int i = 0; i < OUT_CAP; i++) out_buf_d[i] = '0;
    end
    if (abort_i) begin
      state_d = IDLE;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rw20_q     <= 1'b0;
      in_buf_q   <= '0;
      in_fill_q  <= '0;
      out_cnt_q  <= '0;
      words_in_q <= '0;
      coeffs_q   <= '0;
      beats_q    <= '0;
      done_q     <= 1'b0;
      for (int i = 0; i < OUT_CAP; i++) out_buf_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      rw20_q     <= rw20_d;
      in_buf_q   <= in_buf_d;
      in_fill_q  <= in_fill_d;
      out_cnt_q  <= out_cnt_d;
      words_in_q <= words_in_d;
      coeffs_q   <= coeffs_d;
      beats_q    <= beats_d;
      done_q     <= done_d;
      for (int i = 0; i < OUT_CAP; i++) out_buf_q[i] <= out_buf_d[i];
    end
  end

endmodule

// File: tb/tb_expand_mask_sampler.sv
// Scoreboard bench for expand_mask_sampler: fields are packed into squeeze words and the
// expected coefficients (gamma1 - r mod q) are queued, then checked beat by beat.
module tb_expand_mask_sampler;
  localparam int W = 64, SAMPLE_W = 23, BUS_W = 4, LANES = 3, N = 256, Q = 8380417;

  logic                      clk = 1'b0;
  logic                      rst, start_i, abort_i, valid_i, ready_i, ready_o;
  logic                      valid_o, last_o, busy_o, done_o;
  logic [2:0]                sec_lvl;
  logic [W-1:0]              rdi;
  logic [SAMPLE_W*BUS_W-1:0] samples;

  always #5 clk = ~clk;

  expand_mask_sampler #(.W(W), .SAMPLE_W(SAMPLE_W), .BUS_W(BUS_W), .LANES(LANES), .N(N)) dut (
    .clk(clk), .rst(rst), .sec_lvl(sec_lvl), .start_i(start_i), .abort_i(abort_i),
    .valid_i(valid_i), .ready_i(ready_i), .rdi(rdi), .samples(samples), .valid_o(valid_o),
    .ready_o(ready_o), .last_o(last_o), .busy_o(busy_o), .done_o(done_o)
  );

  int           n_chk = 0, n_fail = 0;
  int           exp_q[$];
  int           fields[N];
  logic [W-1:0] words[$];
  int           beat_idx = 0, done_cnt = 0;

  task automatic check_eq(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Pack the field list LSB-first into words and queue the mapped coefficients.
  task automatic build(input int sec);
    int rw, g1, nw, pos, v;
    logic [W-1:0] wt [N*20/W+1];
    rw = (sec == 2) ? 18 : 20;
    g1 = (sec == 2) ? 131072 : 524288;
    nw = (N * rw + W - 1) / W;
    for (int i = 0; i < N*20/W+1; i++) wt[i] = '0;
    for (int j = 0; j < N; j++)
      for (int b = 0; b < rw; b++) begin
        pos = j * rw + b;
        if (fields[j][b]) wt[pos / W][pos % W] = 1'b1;
      end
    words.delete();
    for (int i = 0; i < nw; i++) words.push_back(wt[i]);
    for (int j = 0; j < N; j++) begin
      v = g1 - fields[j];
      if (v < 0) v += Q;
      exp_q.push_back(v);
    end
  endtask

  task automatic rand_fields(input int sec);
    int rw;
    rw = (sec == 2) ? 18 : 20;
    for (int j = 0; j < N; j++) fields[j] = int'($urandom_range(0, (1 << rw) - 1));
  endtask

  always @(negedge clk) begin : monitor
    int e;
    if (!rst) begin
      if (valid_o && ready_o) begin
        for (int b = 0; b < BUS_W; b++) begin
          if (exp_q.size() == 0) check_eq("sb_queue_size", exp_q.size(), BUS_W - b);
          else begin
            e = exp_q.pop_front();
            check_eq($sformatf("coef%0d", beat_idx * BUS_W + b), samples[b*SAMPLE_W +: SAMPLE_W], e);
          end
        end
        check_eq($sformatf("last_o_beat%0d", beat_idx), last_o, beat_idx == N/BUS_W - 1);
        beat_idx++;
      end
      if (done_o) done_cnt++;
    end
  end

  task automatic run_poly(input int sec, input int stall_at, input int stall_len,
                          input int abort_at, input bit rst_drain);
    int nw, widx, cyc, d0;
    bit held_ok, stop;
    logic [SAMPLE_W*BUS_W-1:0] held;
    build(sec);
    nw = words.size();
    beat_idx = 0; d0 = done_cnt; widx = 0; cyc = 0; held_ok = 0; stop = 0; held = '0;
    @(posedge clk); #1;
    sec_lvl = 3'(sec); start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0; sec_lvl = 3'd0;
    check_eq("busy_after_start", busy_o, 1);
    while (!stop && cyc < 4000) begin
      valid_i = 1'b1;
      rdi     = (widx < nw) ? words[widx] : {W{1'b1}};
      ready_o = !(stall_len > 0 && cyc >= stall_at && cyc < stall_at + stall_len);
      abort_i = (abort_at >= 0 && widx == abort_at);
      @(negedge clk);
      if (!ready_o && valid_o) begin
        if (held_ok) check_eq("hold_samples", samples, held);
        else begin held = samples; held_ok = 1; end
      end
      if (stall_len > 0 && cyc == stall_at + stall_len - 1) check_eq("ready_i_stall", ready_i, 0);
      if (abort_i) begin
        @(posedge clk); #1;
        abort_i = 1'b0; valid_i = 1'b0; ready_o = 1'b1;
        exp_q.delete();
        check_eq("busy_after_abort", busy_o, 0);
        check_eq("valid_after_abort", valid_o, 0);
        repeat (10) @(posedge clk);
        #1 check_eq("no_done_after_abort", done_cnt - d0, 0);
        return;
      end
      if (valid_i && ready_i) widx++;
      if (rst_drain && widx == nw) begin
        @(posedge clk); #1;
        valid_i = 1'b0; ready_o = 1'b0;
        check_eq("busy_in_drain", busy_o, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        check_eq("valid_o_after_rst", valid_o, 0);
        check_eq("busy_o_after_rst", busy_o, 0);
        check_eq("done_o_after_rst", done_o, 0);
        rst = 1'b0; ready_o = 1'b1;
        exp_q.delete();
        check_eq("no_done_rst_poly", done_cnt - d0, 0);
        return;
      end
      if (done_cnt != d0) stop = 1;
      cyc++;
      @(posedge clk); #1;
    end
    valid_i = 1'b0; ready_o = 1'b1;
    check_eq("words_accepted", widx, nw);
    repeat (3) @(posedge clk);
    #1;
    check_eq("done_pulses", done_cnt - d0, 1);
    check_eq("sb_empty", exp_q.size(), 0);
    check_eq("busy_end", busy_o, 0);
  endtask

  initial begin
    rst = 1'b1; start_i = 1'b0; abort_i = 1'b0; valid_i = 1'b0; ready_o = 1'b1;
    sec_lvl = 3'd0; rdi = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_ready_i", ready_i, 0);
    check_eq("rst_valid_o", valid_o, 0);
    check_eq("rst_last_o", last_o, 0);
    check_eq("rst_busy_o", busy_o, 0);
    check_eq("rst_done_o", done_o, 0);
    check_eq("rst_samples", samples, 0);
    rst = 1'b0;

    for (int j = 0; j < N; j++) fields[j] = 0;
    run_poly(2, 0, 0, -1, 0);

    rand_fields(3);
    fields[0] = 0; fields[1] = 1048575; fields[2] = 524288; fields[3] = 524289;
    run_poly(3, 0, 0, -1, 0);

    rand_fields(2);
    fields[0] = 262143; fields[1] = 131073;
    run_poly(2, 0, 0, -1, 0);

    rand_fields(3);
    run_poly(3, 40, 200, -1, 0);

    rand_fields(2);
    run_poly(2, 0, 0, 30, 0);
    rand_fields(5);
    run_poly(5, 0, 0, -1, 0);

    rand_fields(5);
    run_poly(5, 0, 0, -1, 1);
    rand_fields(2);
    run_poly(2, 0, 0, -1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish, expected finish before 500000");
    $fatal(1, "timeout");
  end

endmodule
